// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish command sequencer placed in front of a plain stack.
// Operands are pushed directly. Operators pop b, then a, and push a op b.
// The stack has no full/empty flags, so occupancy is tracked here.
module rpn_stack_ctrl #(
  parameter int WIDTH = 18,
  parameter int SIZE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [1:0]       tok_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_top,
  output logic [SIZE:0]    depth,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_POP_B  = 2'd1;
  localparam logic [1:0] S_POP_A  = 2'd2;
  localparam logic [1:0] S_PUSH_R = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  localparam logic [SIZE:0] DEPTH_MAX = {1'b1, {SIZE{1'b0}}};
  localparam logic [SIZE:0] ONE       = (SIZE+1)'(1);
  localparam logic [SIZE:0] TWO       = (SIZE+1)'(2);

  logic [1:0]       state_q, state_d;
  logic [SIZE:0]    depth_q, depth_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result;
  logic             accept;

  assign tok_ready = (state_q == S_IDLE) & ~reset;
  assign accept    = tok_valid & tok_ready;
  assign depth     = depth_q;
  assign res_data  = res_q;

  // Operator datapath; subtraction wraps modulo 2**WIDTH.
  always_comb begin
    unique case (op_q)
      OP_ADD:  result = a_q + b_q;
      OP_SUB:  result = a_q - b_q;
      OP_AND:  result = a_q & b_q;
      default: result = a_q ^ b_q;
    endcase
  end

  // Next-state, occupancy and stack strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    depth_d     = depth_q;
    op_d        = op_q;
    res_d       = res_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    res_valid   = 1'b0;
    err_ovf     = 1'b0;
    err_unf     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!tok_is_op) begin
            if (depth_q < DEPTH_MAX) begin
              stk_push    = 1'b1;
              stk_data_in = tok_data;
              depth_d     = depth_q + ONE;
            end else begin
              err_ovf = 1'b1;
            end
          end else if (depth_q < TWO) begin
            err_unf = 1'b1;
          end else begin
            op_d    = tok_op;
            state_d = S_POP_B;
          end
        end
      end
      S_POP_B: begin
        stk_pop = 1'b1;
        depth_d = depth_q - ONE;
        state_d = S_POP_A;
      end
      S_POP_A: begin
        stk_pop = 1'b1;
        depth_d = depth_q - ONE;
        state_d = S_PUSH_R;
      end
      default: begin
        stk_push    = 1'b1;
        stk_data_in = result;
        res_valid   = 1'b1;
        res_d       = result;
        depth_d     = depth_q + ONE;
        state_d     = S_IDLE;
      end
    endcase
    // Reset aborts whatever is in flight: nothing may reach the stack.
    if (reset) begin
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_data_in = '0;
      res_valid   = 1'b0;
      err_ovf     = 1'b0;
      err_unf     = 1'b0;
    end
  end

  // Control state, occupancy, latched operator and held result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Operand capture from the stack top while popping.
  always_ff @(posedge clk) begin
    // NOTE: a/b are pure datapath, always written before being read, so they carry no reset.
    if (state_q == S_POP_B) b_q <= stk_top;
    if (state_q == S_POP_A) a_q <= stk_top;
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Self-checking bench for rpn_stack_ctrl (WIDTH=18, SIZE=1, DEPTH=2).
// A behavioural stack answers the DUT's push/pop; a queue-based RPN model
// predicts every token's effect.
module tb_rpn_stack_ctrl;

  localparam int W     = 18;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          tok_valid;
  logic          tok_ready;
  logic          tok_is_op;
  logic [1:0]    tok_op;
  logic [W-1:0]  tok_data;
  logic          stk_push;
  logic          stk_pop;
  logic [W-1:0]  stk_data_in;
  logic [W-1:0]  stk_top;
  logic [1:0]    depth;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          err_ovf;
  logic          err_unf;

  int n_tests = 0;
  int n_fail  = 0;

  rpn_stack_ctrl #(.WIDTH(W), .SIZE(1)) dut (
    .clk(clk), .reset(reset),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_op(tok_op), .tok_data(tok_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_top(stk_top), .depth(depth),
    .res_valid(res_valid), .res_data(res_data),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  // Behavioural stack (oversized so a runaway controller is visible).
  logic [W-1:0] mem [0:7];
  logic [3:0]   sp;
  always @(posedge clk) begin
    if (reset) sp <= '0;
    else if (stk_push && sp < 4'd8) begin
      mem[sp[2:0]] <= stk_data_in;
      sp <= sp + 4'd1;
    end else if (stk_pop && sp != 4'd0) sp <= sp - 4'd1;
  end
  assign stk_top = (sp != 4'd0) ? mem[3'(sp - 4'd1)] : '0;

  // Event monitor, sampled mid-cycle.
  int n_push = 0, n_pop = 0, n_res = 0, n_ovf = 0, n_unf = 0;
  int n_overlap = 0, n_both_err = 0, n_deep = 0;
  logic [W-1:0] last_push;
  always @(negedge clk) begin
    if (stk_push) begin
      n_push    <= n_push + 1;
      last_push <= stk_data_in;
    end
    if (stk_pop)   n_pop <= n_pop + 1;
    if (res_valid) n_res <= n_res + 1;
    if (err_ovf)   n_ovf <= n_ovf + 1;
    if (err_unf)   n_unf <= n_unf + 1;
    if (stk_push && stk_pop) n_overlap  <= n_overlap + 1;
    if (err_ovf && err_unf)  n_both_err <= n_both_err + 1;
    if (int'(depth) > DEPTH) n_deep     <= n_deep + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the stack as a plain queue of values.
  logic [W-1:0] model_q[$];

  function automatic logic [W-1:0] rpn_eval(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    tok_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", 32'(tok_ready), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_strobes", {28'd0, stk_push, stk_pop, res_valid, err_ovf | err_unf}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_q.delete();
    @(negedge clk);
    check("post_rst_ready", 32'(tok_ready), 32'd1);
    check("post_rst_res_data", 32'(res_data), 32'd0);
  endtask

  // Present one token, follow it until the controller is ready again, and
  // compare everything it did against the queue model.
  task automatic run_token(input logic is_op, input logic [1:0] op, input logic [W-1:0] data,
                           input logic hold);
    int p_push, p_pop, p_res, p_ovf, p_unf, busy;
    int e_push, e_pop, e_res, e_ovf, e_unf, e_busy;
    logic [W-1:0] e_r, a, b;
    e_push = 0; e_pop = 0; e_res = 0; e_ovf = 0; e_unf = 0; e_busy = 0; e_r = '0;
    if (!is_op) begin
      if (model_q.size() < DEPTH) begin
        model_q.push_back(data); e_push = 1;
      end else e_ovf = 1;
    end else if (model_q.size() < 2) begin
      e_unf = 1;
    end else begin
      b = model_q.pop_back();
      a = model_q.pop_back();
      e_r = rpn_eval(op, a, b);
      model_q.push_back(e_r);
      e_push = 1; e_pop = 2; e_res = 1; e_busy = 3;
    end

    @(posedge clk); #1;
    p_push = n_push; p_pop = n_pop; p_res = n_res; p_ovf = n_ovf; p_unf = n_unf;
    tok_valid = 1'b1; tok_is_op = is_op; tok_op = op; tok_data = data;
    @(negedge clk);
    check("accept_ready", 32'(tok_ready), 32'd1);
    @(posedge clk); #1;
    busy = 0;
    while (!tok_ready && busy < 10) begin
      if (!hold) tok_valid = 1'b0;
      busy++;
      @(posedge clk); #1;
    end
    tok_valid = 1'b0;
    check("busy_cycles", 32'(busy), 32'(e_busy));
    check("push_count", 32'(n_push - p_push), 32'(e_push));
    check("pop_count", 32'(n_pop - p_pop), 32'(e_pop));
    check("res_valid_count", 32'(n_res - p_res), 32'(e_res));
    check("err_ovf_count", 32'(n_ovf - p_ovf), 32'(e_ovf));
    check("err_unf_count", 32'(n_unf - p_unf), 32'(e_unf));
    check("depth", 32'(depth), 32'(model_q.size()));
    if (e_res == 1) begin
      check("res_data", 32'(res_data), 32'(e_r));
      check("pushed_result", 32'(last_push), 32'(e_r));
    end else if (e_push == 1) begin
      check("pushed_operand", 32'(last_push), 32'(data));
    end
  endtask

  // Abort an operator by asserting reset while the controller is in POP_A.
  task automatic reset_in_pop_a();
    int p_push, p_res;
    @(posedge clk); #1;
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_op = 2'd0;
    @(posedge clk); #1;                      // now in POP_B
    check("abort_busy_popb", 32'(tok_ready), 32'd0);
    @(posedge clk); #1;                      // now in POP_A
    p_push = n_push; p_res = n_res;
    reset = 1'b1; tok_valid = 1'b0;
    @(negedge clk);
    check("abort_strobes", {28'd0, stk_push, stk_pop, res_valid, err_ovf | err_unf}, 32'd0);
    check("abort_ready_low", 32'(tok_ready), 32'd0);
    check("abort_data_in", 32'(stk_data_in), 32'd0);
    @(posedge clk); #1;
    check("abort_depth", 32'(depth), 32'd0);
    reset = 1'b0;
    model_q.delete();
    @(negedge clk);
    check("abort_ready_back", 32'(tok_ready), 32'd1);
    check("abort_no_push", 32'(n_push - p_push), 32'd0);
    check("abort_no_result", 32'(n_res - p_res), 32'd0);
  endtask

  initial begin
    tok_valid = 1'b0; tok_is_op = 1'b0; tok_op = 2'd0; tok_data = '0; reset = 1'b1;
    do_reset();

    // add reaching all-ones, then underflow on a single entry
    run_token(1'b0, 2'd0, 18'h15555, 1'b0);
    run_token(1'b0, 2'd0, 18'h2AAAA, 1'b0);
    run_token(1'b1, 2'd0, 18'h00000, 1'b0);
    run_token(1'b1, 2'd3, 18'h00000, 1'b0);

    // wrapping subtraction
    do_reset();
    run_token(1'b0, 2'd0, 18'h00005, 1'b0);
    run_token(1'b0, 2'd0, 18'h00007, 1'b0);
    run_token(1'b1, 2'd1, 18'h00000, 1'b0);

    // overflow on a full stack, then an operator with tok_valid held
    do_reset();
    run_token(1'b0, 2'd0, 18'h00011, 1'b0);
    run_token(1'b0, 2'd0, 18'h00022, 1'b0);
    run_token(1'b0, 2'd0, 18'h00033, 1'b0);
    check("ovf_ready_stays", 32'(tok_ready), 32'd1);
    run_token(1'b1, 2'd2, 18'h00000, 1'b1);

    // reset in the middle of an operator
    do_reset();
    run_token(1'b0, 2'd0, 18'h0ABCD, 1'b0);
    run_token(1'b0, 2'd0, 18'h01234, 1'b0);
    reset_in_pop_a();

    // randomized token stream
    for (int i = 0; i < 400; i++) begin
      logic r_op;
      r_op = ($urandom_range(0, 9) < 4);
      run_token(r_op, 2'($urandom_range(0, 3)), W'($urandom), 1'($urandom_range(0, 1)));
    end

    check("no_push_pop_overlap", 32'(n_overlap), 32'd0);
    check("no_double_error", 32'(n_both_err), 32'd0);
    check("depth_bounded", 32'(n_deep), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
